// File: rtl/adc_interface_if.sv
// Pin-level bundle between the SPI ADC read-out controller and its neighbours:
// serial data from the converter, chip select, and the parallel sample/strobe pair.
interface adc_interface_if #(
    parameter int DATA_W = 12
) ();
    logic              mosi;
    logic              cs_n;
    logic [DATA_W-1:0] data_o;
    logic              valid_o;

    modport master (
        input  mosi,
        output cs_n,
        output data_o,
        output valid_o
    );

    modport slave (
        output mosi,
        input  cs_n,
        input  data_o,
        input  valid_o
    );
endinterface

// File: rtl/adc_interface.sv
// Free-running SPI master that frames a 12-bit ADC read-out and strobes the parallel word.
// Build option ADC_DATA_HOLD_EN: when defined, data_o keeps the last word between strobes.
module adc_interface #(
    parameter int DATA_W    = 12,
    parameter int LEAD_BITS = 1,
    parameter int FRAME_LEN = 16,
    parameter int IDLE_LEN  = 2
) (
    input  logic            sck,
    input  logic            rst,
    adc_interface_if.master adc
);
    localparam int CNT_MAX = (FRAME_LEN > IDLE_LEN) ? FRAME_LEN : IDLE_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] FIRST_BIT = CNT_W'(LEAD_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(LEAD_BITS + DATA_W);
    localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] IDLE_END  = CNT_W'(IDLE_LEN - 1);

    typedef enum logic {
        ST_IDLE,
        ST_CONV
    } state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              cs_n_reg;
    logic [DATA_W-1:0] sr_reg;
    logic [DATA_W-1:0] data_reg;
    logic              valid_reg;

    logic [CNT_W-1:0]  k_next;
    logic [DATA_W-1:0] sample_next;
    logic              in_data;

    // In CONV cnt_reg holds the bit index of the previous edge, so k_next is
    // the index of the edge currently being taken.
    assign k_next  = cnt_reg + CNT_W'(1);
    assign in_data = (k_next >= FIRST_BIT) && (k_next <= LAST_BIT);

    assign sample_next[0] = adc.mosi;
    generate
        for (genvar gi = 1; gi < DATA_W; gi++) begin : g_shift
            assign sample_next[gi] = sr_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge sck) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            cs_n_reg  <= 1'b1;
            sr_reg    <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
`ifndef ADC_DATA_HOLD_EN
            data_reg  <= '0;
`endif
            case (state_reg)
                ST_IDLE: begin
                    if (cnt_reg == IDLE_END) begin
                        state_reg <= ST_CONV;
                        cnt_reg   <= '0;
                        cs_n_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_CONV: begin
                    if (in_data) begin
                        sr_reg <= sample_next;
                    end
                    // The LSB is taken straight from the pin so the word lands
                    // on the same edge that samples it.
                    if (k_next == LAST_BIT) begin
                        data_reg  <= sample_next;
                        valid_reg <= 1'b1;
                    end
                    if (k_next == FRAME_END) begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                        cs_n_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= k_next;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                    cs_n_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign adc.cs_n    = cs_n_reg;
    assign adc.data_o  = data_reg;
    assign adc.valid_o = valid_reg;

endmodule

// File: tb/tb_adc_interface.sv
// Bench for adc_interface: an ADC pin model plus a scoreboard of expected samples,
// driven by a table of frames and hand-written reset sequences.
module tb_adc_interface;
    localparam int DATA_W    = 12;
    localparam int LEAD_BITS = 1;
    localparam int FRAME_LEN = 16;
    localparam int IDLE_LEN  = 2;
    localparam int LSB_K     = LEAD_BITS + DATA_W;
    localparam int PERIOD    = FRAME_LEN + IDLE_LEN;

    logic sck = 1'b0;
    logic rst = 1'b0;

    adc_interface_if #(.DATA_W(DATA_W)) adc_bus ();

    adc_interface #(
        .DATA_W    (DATA_W),
        .LEAD_BITS (LEAD_BITS),
        .FRAME_LEN (FRAME_LEN),
        .IDLE_LEN  (IDLE_LEN)
    ) dut (
        .sck (sck),
        .rst (rst),
        .adc (adc_bus)
    );

    always #5 sck = ~sck;

    typedef struct {
        logic [DATA_W-1:0] word;
        logic              lead;
        logic              trail;
        logic [DATA_W-1:0] exp_data;
        string             name;
    } vec_t;

    vec_t              vecs[6];
    vec_t              tx_q[$];
    vec_t              cur;
    logic [DATA_W-1:0] exp_q[$];

    int checks   = 0;
    int failures = 0;

    int   cycle            = 0;
    int   k_mon            = 0;
    logic prev_cs          = 1'b1;
    int   hi_run           = 0;
    bit   after_reset      = 1'b1;
    int   fall_cycle       = 0;
    int   pulse_count      = 0;
    int   last_pulse_cycle = 0;
    logic [DATA_W-1:0] last_pulse_data = '0;
    logic [DATA_W-1:0] hold_exp        = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=0x%0h required=0x%0h", name, cycle, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s cycle=%0d timed out or unexpected event", name, cycle);
    endtask

    // One sck period: observe outputs on the falling edge, then act as the ADC
    // and present the bit that the next rising edge will sample.
    task automatic step();
        int m;
        @(negedge sck);
        cycle++;
        if (rst !== 1'b1) begin
            check("reset_cs_n",  32'(adc_bus.cs_n),    32'd1);
            check("reset_valid", 32'(adc_bus.valid_o), 32'd0);
            check("reset_data",  32'(adc_bus.data_o),  32'd0);
            exp_q.delete();
            k_mon       = 0;
            prev_cs     = 1'b1;
            hi_run      = 0;
            after_reset = 1'b1;
            hold_exp    = '0;
            adc_bus.mosi = 1'($urandom);
            $display("cycle=%0d reset cs_n=%0b valid=%0b data=0x%03h",
                     cycle, adc_bus.cs_n, adc_bus.valid_o, adc_bus.data_o);
            return;
        end

        if (adc_bus.cs_n === 1'b0) begin
            if (prev_cs === 1'b1) begin
                check("cs_high_len", 32'(hi_run), 32'(after_reset ? IDLE_LEN - 1 : IDLE_LEN));
                after_reset = 1'b0;
                k_mon       = 0;
                fall_cycle  = cycle;
                if (tx_q.size() > 0) begin
                    cur = tx_q.pop_front();
                end else begin
                    cur.word     = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
                    cur.lead     = 1'($urandom);
                    cur.trail    = 1'($urandom);
                    cur.exp_data = cur.word;
                    cur.name     = "random";
                end
                exp_q.push_back(cur.exp_data);
            end else begin
                k_mon++;
            end
        end else begin
            if (prev_cs === 1'b0) begin
                check("cs_low_len", 32'(k_mon + 1), 32'(FRAME_LEN));
                hi_run = 1;
            end else begin
                hi_run++;
            end
        end
        prev_cs = adc_bus.cs_n;

        check("valid_timing", 32'(adc_bus.valid_o),
              32'((adc_bus.cs_n === 1'b0) && (k_mon == LSB_K)));

        if (adc_bus.valid_o === 1'b1) begin
            pulse_count++;
            last_pulse_cycle = cycle;
            last_pulse_data  = adc_bus.data_o;
            if (exp_q.size() == 0) begin
                fail_now("unexpected_pulse");
            end else begin
                hold_exp = exp_q.pop_front();
                check("sb_data", 32'(adc_bus.data_o), 32'(hold_exp));
            end
            $display("cycle=%0d pulse data=0x%03h expected=0x%03h",
                     cycle, adc_bus.data_o, hold_exp);
        end else begin
`ifdef ADC_DATA_HOLD_EN
            check("data_hold", 32'(adc_bus.data_o), 32'(hold_exp));
`else
            check("data_zero", 32'(adc_bus.data_o), 32'd0);
`endif
        end

        if (adc_bus.cs_n === 1'b0) begin
            m = k_mon + 1;
            if (m <= LEAD_BITS)
                adc_bus.mosi = cur.lead;
            else if (m <= LSB_K)
                adc_bus.mosi = cur.word[DATA_W - 1 - (m - LEAD_BITS - 1)];
            else
                adc_bus.mosi = cur.trail;
        end else begin
            adc_bus.mosi = 1'($urandom);
        end
    endtask

    task automatic wait_pulse(input string name, output bit ok);
        int start;
        int n;
        start = pulse_count;
        n     = 0;
        while (pulse_count == start && n < 3 * PERIOD) begin
            step();
            n++;
        end
        ok = (pulse_count != start);
        if (!ok) fail_now(name);
    endtask

    initial begin
        bit ok;
        int prev_pulse;
        int n;
        int pulses_before;

        vecs[0] = '{word: 12'h48F, lead: 1'b1, trail: 1'b0, exp_data: 12'h48F, name: "frame_48f"};
        vecs[1] = '{word: 12'hFFF, lead: 1'b1, trail: 1'b1, exp_data: 12'hFFF, name: "frame_fff"};
        vecs[2] = '{word: 12'h000, lead: 1'b0, trail: 1'b0, exp_data: 12'h000, name: "frame_000"};
        vecs[3] = '{word: 12'h48F, lead: 1'b1, trail: 1'b1, exp_data: 12'h48F, name: "trail_ones"};
        vecs[4] = '{word: 12'h5A3, lead: 1'b0, trail: 1'b1, exp_data: 12'h5A3, name: "frame_5a3"};
        vecs[5] = '{word: 12'h801, lead: 1'b1, trail: 1'b0, exp_data: 12'h801, name: "frame_801"};

        adc_bus.mosi = 1'b0;
        rst          = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        foreach (vecs[i]) tx_q.push_back(vecs[i]);

        step();
        check("release_edge1_cs_n", 32'(adc_bus.cs_n), 32'd1);
        step();
        check("release_edge2_cs_n", 32'(adc_bus.cs_n), 32'd0);

        prev_pulse = 0;
        for (int i = 0; i < 6; i++) begin
            wait_pulse({"pulse_", vecs[i].name}, ok);
            if (ok) begin
                check(vecs[i].name, 32'(last_pulse_data), 32'(vecs[i].exp_data));
                check("lsb_latency", 32'(last_pulse_cycle - fall_cycle), 32'(LSB_K));
                if (i > 0)
                    check("pulse_spacing", 32'(last_pulse_cycle - prev_pulse), 32'(PERIOD));
                prev_pulse = last_pulse_cycle;
            end
        end

        // Abort a frame with reset on the k=6 edge, then capture a fresh word.
        n = 0;
        while (!(adc_bus.cs_n === 1'b0 && k_mon == 5) && n < 3 * PERIOD) begin
            step();
            n++;
        end
        if (!(adc_bus.cs_n === 1'b0 && k_mon == 5)) fail_now("reach_k5");
        rst = 1'b0;
        pulses_before = pulse_count;
        step();
        rst = 1'b1;
        tx_q.delete();
        tx_q.push_back('{word: 12'hA5A, lead: 1'b1, trail: 1'b1, exp_data: 12'hA5A, name: "after_abort"});
        wait_pulse("pulse_after_abort", ok);
        if (ok) begin
            check("after_abort_data", 32'(last_pulse_data), 32'h0000_0A5A);
            check("after_abort_pulses", 32'(pulse_count - pulses_before), 32'd1);
        end

        repeat (PERIOD) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
